// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT: one time-shared butterfly, parallel frame in/out.
// Optional macro FFT_STAGE_SCALE_EN: halve every butterfly output (round-half-up) instead of saturating.
module fft_radix2_iter #(
    parameter int N    = 8,
    parameter int W    = 32,
    parameter int TW_W = 18
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           inverse,
    input  logic [N*W-1:0] data_in_r,
    input  logic [N*W-1:0] data_in_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] data_out_r,
    output logic [N*W-1:0] data_out_i,
    output logic           busy
);
    localparam int LOGN = $clog2(N);
    localparam int PW   = W + TW_W;
    localparam int SH   = TW_W - 2;
    localparam logic signed [PW:0] RND = (PW+1)'(2**(SH-1));

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic signed [W-1:0]    mem_r [N];
    logic signed [W-1:0]    mem_i [N];
    logic [LOGN-1:0]        stg;
    logic [LOGN-2:0]        bfy;
    logic                   inv_q;
    logic                   last;

    logic signed [TW_W-1:0] tw_r [N/2];
    logic signed [TW_W-1:0] tw_i [N/2];

    // Elaboration-time twiddle: cos for im=0, -sin for im=1, scaled to Q(TW_W-2), rounded to nearest.
    function automatic int tw_val(input int k, input bit im);
        real a, v;
        a = 2.0 * 3.14159265358979323846 * real'(k) / real'(N);
        v = (im ? -$sin(a) : $cos(a)) * (2.0 ** SH);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    for (genvar k = 0; k < N/2; k++) begin : g_tw
        localparam int TR = tw_val(k, 1'b0);
        localparam int TI = tw_val(k, 1'b1);
        assign tw_r[k] = TR[TW_W-1:0];
        assign tw_i[k] = TI[TW_W-1:0];
    end

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = x[LOGN-1-i];
        return r;
    endfunction

    // Reduce a W+1-bit butterfly result to the W-bit working width.
    function automatic logic signed [W-1:0] fin(input logic signed [W:0] x);
`ifdef FFT_STAGE_SCALE_EN
        return W'(((W+2)'(x) + (W+2)'(1)) >>> 1);
`else
        if (x[W] != x[W-1])
            return x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            return x[W-1:0];
`endif
    endfunction

    // Butterfly addressing and arithmetic
    logic [LOGN-2:0]        span_m1, b_lo, tw_sel;
    logic [LOGN-1:0]        top_idx, bot_idx;
    logic signed [W-1:0]    ar, ai, br, bi;
    logic signed [TW_W-1:0] wr, wi;
    logic signed [PW-1:0]   m_rr, m_ii, m_ri, m_ir;
    logic signed [PW:0]     pr, pi;
    logic signed [W:0]      t_r, t_i, sum_r, sum_i, dif_r, dif_i;

    always_comb begin
        span_m1 = (LOGN-1)'((1 << stg) - 1);
        b_lo    = bfy & span_m1;
        top_idx = LOGN'(((int'(bfy) >> stg) << (int'(stg) + 1)) + int'(b_lo));
        bot_idx = LOGN'(int'(top_idx) + (1 << stg));
        tw_sel  = (LOGN-1)'(int'(b_lo) << (LOGN - 1 - int'(stg)));
        ar = mem_r[top_idx];
        ai = mem_i[top_idx];
        br = mem_r[bot_idx];
        bi = mem_i[bot_idx];
        wr = tw_r[tw_sel];
        wi = inv_q ? -tw_i[tw_sel] : tw_i[tw_sel];
        m_rr = PW'(br) * PW'(wr);
        m_ii = PW'(bi) * PW'(wi);
        m_ri = PW'(br) * PW'(wi);
        m_ir = PW'(bi) * PW'(wr);
        pr = (PW+1)'(m_rr) - (PW+1)'(m_ii);
        pi = (PW+1)'(m_ri) + (PW+1)'(m_ir);
        t_r = (W+1)'((pr + RND) >>> SH);
        t_i = (W+1)'((pi + RND) >>> SH);
        sum_r = (W+1)'(ar) + t_r;
        sum_i = (W+1)'(ai) + t_i;
        dif_r = (W+1)'(ar) - t_r;
        dif_i = (W+1)'(ai) - t_i;
    end

    assign last = (stg == LOGN'(LOGN-1)) && (&bfy);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst;
                if (in_valid && rst) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working array: bit-reversed load on accept, one butterfly pair rewritten per CALC cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                mem_r[k] <= '0;
                mem_i[k] <= '0;
            end
            stg   <= '0;
            bfy   <= '0;
            inv_q <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                for (int k = 0; k < N; k++) begin
                    mem_r[bitrev(LOGN'(k))] <= data_in_r[k*W +: W];
                    mem_i[bitrev(LOGN'(k))] <= data_in_i[k*W +: W];
                end
                inv_q <= inverse;
                stg   <= '0;
                bfy   <= '0;
            end
        end else if (state == CALC) begin
            mem_r[top_idx] <= fin(sum_r);
            mem_i[top_idx] <= fin(sum_i);
            mem_r[bot_idx] <= fin(dif_r);
            mem_i[bot_idx] <= fin(dif_i);
            bfy <= bfy + 1'b1;
            if (&bfy) stg <= last ? '0 : stg + 1'b1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign data_out_r[k*W +: W] = mem_r[k];
        assign data_out_i[k*W +: W] = mem_i[k];
    end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Directed + randomized bench for fft_radix2_iter (N=8); reference is a direct floating-point DFT.
module tb_fft_radix2_iter;
    localparam int N = 8, W = 32, TW_W = 18;

    logic           clk = 1'b0, rst = 1'b0;
    logic           in_valid = 1'b0, inverse = 1'b0, out_ready = 1'b0;
    logic           in_ready, out_valid, busy;
    logic [N*W-1:0] data_in_r = '0, data_in_i = '0;
    logic [N*W-1:0] data_out_r, data_out_i, snap_r, snap_i;

    int tests = 0, fails = 0, lat = 0;
    longint xr[N], xi[N], yr[N], yi[N], hr[N], hi[N];
    real er[N], ei[N];
    real gain = 1.0;

    always #5 clk = ~clk;

    fft_radix2_iter #(.N(N), .W(W), .TW_W(TW_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inverse(inverse),
        .data_in_r(data_in_r), .data_in_i(data_in_i), .out_valid(out_valid), .out_ready(out_ready),
        .data_out_r(data_out_r), .data_out_i(data_out_i), .busy(busy)
    );

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input int k, input longint obs, input real exp, input real tol);
        tests++;
        assert (rabs(real'(obs) - exp) <= tol) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%0d expected=%0f (tol %0f)", tag, k, obs, exp, tol);
        end
    endtask

    // Direct DFT of xr/xi; inverse flips the exponent sign.
    task automatic dft(input bit inv);
        real a, c, s, sg;
        sg = inv ? 1.0 : -1.0;
        for (int k = 0; k < N; k++) begin
            er[k] = 0.0;
            ei[k] = 0.0;
            for (int n = 0; n < N; n++) begin
                a = 2.0 * 3.14159265358979323846 * real'(k * n) / real'(N);
                c = $cos(a);
                s = sg * $sin(a);
                er[k] += real'(xr[n]) * c - real'(xi[n]) * s;
                ei[k] += real'(xr[n]) * s + real'(xi[n]) * c;
            end
            er[k] *= gain;
            ei[k] *= gain;
        end
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            data_in_r[k*W +: W] = xr[k][W-1:0];
            data_in_i[k*W +: W] = xi[k][W-1:0];
        end
    endtask

    // Present a frame, wait for its accept edge, then scramble the idle inputs.
    task automatic send(input bit inv);
        int g;
        pack();
        inverse  = inv;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("accept_wait", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        inverse  = ~inv;
        for (int k = 0; k < N; k++) begin
            data_in_r[k*W +: W] = $urandom;
            data_in_i[k*W +: W] = $urandom;
        end
        lat = 1;
    endtask

    // lat counts clock edges with the accept edge as 1.
    task automatic wait_out(input bit check_lat);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid", out_valid, 1);
        if (check_lat) chk("latency", lat, 13);
        for (int k = 0; k < N; k++) begin
            yr[k] = longint'($signed(data_out_r[k*W +: W]));
            yi[k] = longint'($signed(data_out_i[k*W +: W]));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after_ready", out_valid, 0);
        chk("in_ready_after_ready", in_ready, 1);
    endtask

    task automatic check_model(input string tag, input real tol);
        for (int k = 0; k < N; k++) begin
            chk_tol({tag, "_re"}, k, yr[k], er[k], tol);
            chk_tol({tag, "_im"}, k, yi[k], ei[k], tol);
        end
    endtask

    task automatic set_impulse();
        for (int k = 0; k < N; k++) begin
            xr[k] = (k == 0) ? 65536 : 0;
            xi[k] = 0;
        end
    endtask

    initial begin
`ifdef FFT_STAGE_SCALE_EN
        gain = 1.0 / real'(N);
`endif
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        tests++;
        assert (data_out_r === '0 && data_out_i === '0) else begin
            fails++;
            $error("FAIL rst_data observed=%h expected=0", data_out_r[63:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // Impulse
        set_impulse();
        send(1'b0);
        chk("busy_calc", busy, 1);
        chk("in_ready_calc", in_ready, 0);
        wait_out(1'b1);
        dft(1'b0);
        check_model("impulse", 4.0);
        release_out();

        // Ramp, keep its spectrum for the round trip
        for (int n = 0; n < N; n++) begin
            xr[n] = longint'(n) << 12;
            xi[n] = 0;
        end
        send(1'b0);
        wait_out(1'b1);
        dft(1'b0);
        check_model("ramp", 4.0);
        hr = yr;
        hi = yi;
        release_out();

        // Round trip: inverse of the ramp spectrum returns 8*x (or x/8 when every stage halves)
        xr = hr;
        xi = hi;
        send(1'b1);
        wait_out(1'b1);
        for (int n = 0; n < N; n++) begin
`ifdef FFT_STAGE_SCALE_EN
            chk_tol("roundtrip_re", n, yr[n], real'(n * 4096) / 8.0, 16.0);
`else
            chk_tol("roundtrip_re", n, yr[n], real'(n * 4096) * 8.0, 16.0);
`endif
            chk_tol("roundtrip_im", n, yi[n], 0.0, 16.0);
        end
        release_out();

        // DC
        for (int n = 0; n < N; n++) begin
            xr[n] = 65536;
            xi[n] = 0;
        end
        send(1'b0);
        wait_out(1'b1);
        dft(1'b0);
        check_model("dc", 2.0);
        release_out();

        // Random frames, random direction
        for (int f = 0; f < 4; f++) begin
            bit inv;
            for (int n = 0; n < N; n++) begin
                xr[n] = longint'($urandom_range(131072, 0)) - 65536;
                xi[n] = longint'($urandom_range(131072, 0)) - 65536;
            end
            inv = 1'($urandom_range(1, 0));
            send(inv);
            wait_out(1'b1);
            dft(inv);
            check_model(inv ? "rand_ifft" : "rand_fft", 8.0);
            release_out();
        end

        // Back-pressure with a second frame already waiting
        for (int n = 0; n < N; n++) begin
            xr[n] = longint'($urandom_range(131072, 0)) - 65536;
            xi[n] = longint'($urandom_range(131072, 0)) - 65536;
        end
        send(1'b0);
        wait_out(1'b1);
        dft(1'b0);
        check_model("bp_frame", 8.0);
        snap_r = data_out_r;
        snap_i = data_out_i;
        set_impulse();
        pack();
        inverse  = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            tests++;
            assert (data_out_r === snap_r && data_out_i === snap_i) else begin
                fails++;
                $error("FAIL bp_data_stable cycle=%0d observed=%h expected=%h", c, data_out_r[63:0], snap_r[63:0]);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        @(negedge clk);
        chk("bp_second_accepted", busy, 1);
        in_valid = 1'b0;
        lat = 1;
        wait_out(1'b1);
        dft(1'b0);
        check_model("bp_second", 4.0);
        release_out();

        // Reset in the middle of CALC
        for (int n = 0; n < N; n++) begin
            xr[n] = longint'(n) << 12;
            xi[n] = 0;
        end
        send(1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_release_in_ready", in_ready, 1);
        begin
            int seen = 0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("midrst_no_stale_valid", seen, 0);
        end
        set_impulse();
        send(1'b0);
        wait_out(1'b1);
        dft(1'b0);
        check_model("midrst_impulse", 4.0);
        release_out();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_radix2_iter.md
Name: fft_radix2_iter

Overview:
- Parametrised, iterative, in-place radix-2 decimation-in-time FFT/IFFT engine. It is the successor to the fixed 8-point FFT.
- Accepts one N-point complex frame in parallel and computes it with a single time-shared butterfly. It returns the N-point result in parallel.
- Valid/ready handshake on both sides; supports frame back-pressure and a per-frame inverse mode.
- Sits between the sample framer and the spectral post-processing in the same clock domain.

Parameters:
- N, 8, transform length; power of two, 4..1024.
- W, 32, signed width of each real/imag sample (fixed point, interpretation left to user; benches use Q16).
- TW_W, 18, signed twiddle width, format Q(TW_W-2) so +1.0 is exactly representable.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset (0 = reset, sampled on clk).
- in_valid  in  1  input frame valid.
- in_ready  out  1  engine can accept a frame.
- inverse  in  1  sampled with the frame; 1 = IFFT (conjugated twiddles), 0 = FFT.
- data_in_r  in  N*W  real parts; sample k at bits [k*W +: W].
- data_in_i  in  N*W  imag parts, same packing.
- out_valid  out  1  result frame valid.
- out_ready  in  1  downstream accepts result.
- data_out_r  out  N*W  real result, natural order, same packing.
- data_out_i  out  N*W  imag result.
- busy  out  1  high in CALC.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, in_ready=0 during reset then 1 on first cycle after, out_valid=0, busy=0, data_out_*=0, stage/butterfly counters=0. Reset mid-CALC or mid-DONE aborts the frame; no partial output is ever flagged valid.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load all N samples into the working array in bit-reversed index order, latch inverse, and go to CALC.
  - CALC: in_ready=0, busy=1. Stage s=0..log2(N)-1; butterfly b=0..N/2-1; one butterfly per cycle (read pair, write pair in same cycle, registered array).
    - Pair indices: span=2^s; top=((b>>s)<<(s+1))+(b&(span-1)); bot=top+span.
    - Twiddle index: (b&(span-1))<<(log2N-1-s).
    - Butterfly: t=bot*W; top'=top+t; bot'=top-t.
    - After last butterfly of last stage go to DONE.
  - DONE: out_valid=1, data_out_* driven from working array. On out_ready go to IDLE (in_ready=1 next cycle). out_valid holds and data stays stable while out_ready=0.
- Latency: accept edge to out_valid = (N/2)*log2(N)+1 cycles (N=8: 13).
- Twiddle ROM: W_k=cos(2πk/N) - j·sin(2πk/N), k=0..N/2-1. Computed at elaboration and rounded to nearest. inverse=1 negates the sin term. No output 1/N scaling is applied in inverse mode unless the optional feature supplies it.
- Complex multiply: full W+TW_W products, sums, then round-half-up shift right by TW_W-2, truncated to W+1 bits internally.
- Butterfly add/sub computed at W+1 bits, then the result per the optional feature.
- inverse and data_in are ignored outside the accept handshake.
- in_valid while not in_ready is held off and is not lost (the sender keeps it asserted).

Optional Feature:
- Macro FFT_STAGE_SCALE_EN.
- Defined: every butterfly output is arithmetically shifted right by 1 (round-half-up) before writeback. Total gain is 1/N, so no overflow is possible.
- Undefined: no scaling; butterfly outputs saturate to the W-bit signed range (max 2^(W-1)-1, min -2^(W-1)).

Test Plan:
- Impulse, N=8, W=32, scale off: x[0]=65536, rest 0 -> all X[k]=65536+0i; out_valid exactly 13 cycles after accept.
- Ramp, scale off: x[n]=n<<12 -> X[0]=114688, X[4]=-16384+0i, X[2]=-16384+16384i, X[6]=-16384-16384i. Tolerance ±4 LSB on all bins.
- DC with FFT_STAGE_SCALE_EN: all x[n]=65536 -> X[0]=65536, X[1..7]=0 (±2 LSB).
- Round trip: FFT of the ramp, feed the result with inverse=1 (scale off) -> output = 8·x[n] ±16 LSB. With scaling enabled in both passes -> x[n]/8 ±16 LSB.
- Back-pressure: out_ready=0 for 20 cycles in DONE -> out_valid and data stable, in_ready=0; a second frame is accepted only in the cycle after out_ready=1.
- Reset mid-CALC: rst=0 at cycle 5 of CALC -> out_valid=0, in_ready=1 after release; the next frame (impulse) produces the correct result.
